// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data + odd parity + stop, ACK check.
// Optional PS2_TX_RETRY_EN: retry a failed frame up to twice before reporting an error.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       master_clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CW = $clog2(INHIBIT_CYCLES);
  localparam logic [CW-1:0] DATA_AT = CW'(INHIBIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] REL_AT = CW'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] TO_AT = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [19:0] timer_q, timer_n;
  logic [9:0] shift_q, shift_n;
  logic [3:0] bit_cnt_q, bit_cnt_n;
  logic clk_oe_q, clk_oe_n;
  logic data_oe_q, data_oe_n;
  logic done_q, done_n;
  logic error_q, error_n;
  logic [1:0] clk_sync_q, data_sync_q;
  logic clk_prev_q;
  logic clk_s, data_s, fall, timeout, fail;
`ifdef PS2_TX_RETRY_EN
  logic [9:0] frame_q, frame_n;
  logic [1:0] retry_q, retry_n;
`endif

  assign clk_s = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall = ({clk_prev_q, clk_s} == 2'b10);
  assign timeout = (timer_q == TO_AT);

  assign tx_busy = (state_q != IDLE);
  assign tx_done = done_q;
  assign tx_error = error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      timer_q <= '0;
      shift_q <= '0;
      bit_cnt_q <= '0;
      clk_oe_q <= 1'b0;
      data_oe_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      clk_sync_q <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
`ifdef PS2_TX_RETRY_EN
      frame_q <= '0;
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q <= cnt_n;
      timer_q <= timer_n;
      shift_q <= shift_n;
      bit_cnt_q <= bit_cnt_n;
      clk_oe_q <= clk_oe_n;
      data_oe_q <= data_oe_n;
      done_q <= done_n;
      error_q <= error_n;
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q <= clk_s;
`ifdef PS2_TX_RETRY_EN
      frame_q <= frame_n;
      retry_q <= retry_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n = cnt_q;
    timer_n = timer_q;
    shift_n = shift_q;
    bit_cnt_n = bit_cnt_q;
    clk_oe_n = clk_oe_q;
    data_oe_n = data_oe_q;
    done_n = 1'b0;
    error_n = 1'b0;
    fail = 1'b0;
`ifdef PS2_TX_RETRY_EN
    frame_n = frame_q;
    retry_n = retry_q;
`endif
    unique case (state_q)
      IDLE: begin
        clk_oe_n = 1'b0;
        data_oe_n = 1'b0;
        if (tx_start) begin
          shift_n = {1'b1, ~^tx_data, tx_data};
          cnt_n = '0;
          clk_oe_n = 1'b1;
          state_n = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          frame_n = {1'b1, ~^tx_data, tx_data};
          retry_n = '0;
`endif
        end
      end
      INHIBIT: begin
        cnt_n = cnt_q + CW'(1);
        if (cnt_q == DATA_AT) data_oe_n = 1'b1;
        if (cnt_q == REL_AT) begin
          clk_oe_n = 1'b0;
          timer_n = '0;
          bit_cnt_n = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        timer_n = timer_q + 20'd1;
        if (timeout) begin
          fail = 1'b1;
        end else if (fall) begin
          data_oe_n = ~shift_q[0];
          shift_n = {1'b0, shift_q[9:1]};
          bit_cnt_n = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_n = ACK;
        end
      end
      ACK: begin
        timer_n = timer_q + 20'd1;
        if (timeout) fail = 1'b1;
        else if (fall) begin
          if (!data_s) state_n = WAIT_IDLE;
          else fail = 1'b1;
        end
      end
      WAIT_IDLE: begin
        timer_n = timer_q + 20'd1;
        if (timeout) begin
          fail = 1'b1;
        end else if (clk_s && data_s) begin
          done_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Failure releases both lines; timeout already took priority above
    if (fail) begin
      clk_oe_n = 1'b0;
      data_oe_n = 1'b0;
      state_n = IDLE;
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_n = retry_q + 2'd1;
        shift_n = frame_q;
        cnt_n = '0;
        clk_oe_n = 1'b1;
        state_n = INHIBIT;
      end else begin
        error_n = 1'b1;
      end
`else
      error_n = 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on wired-AND lines, frame model, per-cycle monitor.
// Shortened inhibit/timeout parameters keep the run small.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int TO = 3000;

  logic master_clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_start = 1'b0;
  logic tx_busy, tx_done, tx_error;
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic clk_line, data_line;

  assign clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .master_clk(master_clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .ps2_clk_in(clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #10 master_clk = ~master_clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int err_cyc = 0;
  int inh_run = 0;
  int data_rise = -1;
  int inh_phases = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit model_busy = 1'b0;
  logic prev_clk_oe = 1'b0;

  always @(posedge master_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Per-cycle compare against the transaction-level model
  always @(negedge master_clk) begin
    if (!rst) begin
      model_busy = 1'b0;
      inh_run = 0;
      data_rise = -1;
      prev_clk_oe = 1'b0;
    end else begin
      if (tx_done || tx_error) model_busy = 1'b0;
      check("busy", tx_busy, model_busy);
      check("done_err_excl", tx_done & tx_error, 0);
      if (!model_busy) check("oe_idle", {ps2_clk_oe, ps2_data_oe}, 0);
      if (ps2_clk_oe) begin
        if (!prev_clk_oe) inh_phases++;
        inh_run++;
        if (ps2_data_oe && data_rise < 0) data_rise = inh_run;
      end else if (prev_clk_oe) begin
        check("inhibit_len", inh_run, INH);
        check("data_lead", INH - data_rise + 1, INH / 2);
        inh_run = 0;
        data_rise = -1;
      end
      done_cnt += int'(tx_done);
      err_cnt += int'(tx_error);
      if (tx_error) err_cyc = cyc;
      prev_clk_oe = ps2_clk_oe;
    end
  end

  task automatic start(input logic [7:0] d);
    @(posedge master_clk);
    #1;
    tx_data = d;
    tx_start = 1'b1;
    @(posedge master_clk);
    #1;
    acc_cyc = cyc;
    model_busy = 1'b1;
    tx_start = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic device(input int half, input bit ack, input int poke_bit,
                        input int rst_bit, output logic [10:0] got);
    int n;
    got = '0;
    n = 0;
    while (!ps2_clk_oe && n < 1000) begin
      @(negedge master_clk);
      n++;
    end
    check("bfm_request", ps2_clk_oe, 1);
    n = 0;
    while (ps2_clk_oe && n < INH + 50) begin
      @(negedge master_clk);
      n++;
    end
    check("bfm_release", ps2_clk_oe, 0);
    repeat (half) @(negedge master_clk);
    got[0] = data_line;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (half) @(negedge master_clk);
      if (i == rst_bit) begin
        rst = 1'b0;
        #1;
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", tx_busy, 0);
        dev_clk_low = 1'b0;
        return;
      end
      if (i == poke_bit) begin
        tx_data = 8'h00;
        tx_start = 1'b1;
        @(posedge master_clk);
        #1;
        tx_start = 1'b0;
      end
      dev_clk_low = 1'b0;
      #1;
      got[i] = data_line;
      repeat (half) @(negedge master_clk);
    end
    if (ack) dev_data_low = 1'b1;
    repeat (half / 2) @(negedge master_clk);
    dev_clk_low = 1'b1;
    repeat (half) @(negedge master_clk);
    dev_clk_low = 1'b0;
    repeat (half / 2) @(negedge master_clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy && n < 2000) begin
      @(negedge master_clk);
      n++;
    end
    repeat (2) @(negedge master_clk);
    check("idle_reached", tx_busy, 0);
  endtask

  task automatic run_ok(input logic [7:0] b, input int half, input bit use_lit,
                        input logic [10:0] lit, input int poke);
    int d0, e0, i0;
    logic [10:0] got;
    d0 = done_cnt;
    e0 = err_cnt;
    i0 = inh_phases;
    start(b);
    device(half, 1'b1, poke, -1, got);
    wait_idle();
    check("frame", got, use_lit ? lit : model_frame(b));
    check("done_count", done_cnt - d0, 1);
    check("err_count", err_cnt - e0, 0);
    check("inhibit_phases", inh_phases - i0, 1);
  endtask

  initial begin
    logic [10:0] got;
    int d0, e0, i0, n;
    repeat (3) @(negedge master_clk);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_error", tx_error, 0);
    rst = 1'b1;
    repeat (3) @(negedge master_clk);

    run_ok(8'hED, 20, 1'b1, 11'h7DA, -1);
    run_ok(8'hF4, 25, 1'b1, 11'h5E8, -1);
    for (int k = 0; k < 6; k++)
      run_ok(8'($urandom), int'($urandom_range(10, 30)), 1'b0, 11'h0, -1);

    run_ok(8'h5A, 20, 1'b0, 11'h0, 3);

    start(8'hED);
    device(20, 1'b1, -1, 5, got);
    repeat (3) @(negedge master_clk);
    rst = 1'b1;
    repeat (3) @(negedge master_clk);
    run_ok(8'hF4, 20, 1'b1, 11'h5E8, -1);

`ifndef PS2_TX_RETRY_EN
    d0 = done_cnt;
    e0 = err_cnt;
    start(8'h3C);
    device(20, 1'b0, -1, -1, got);
    wait_idle();
    check("nack_frame", got, model_frame(8'h3C));
    check("nack_err", err_cnt - e0, 1);
    check("nack_done", done_cnt - d0, 0);
    check("nack_oe", {ps2_clk_oe, ps2_data_oe}, 0);

    e0 = err_cnt;
    start(8'h11);
    n = 0;
    while (err_cnt == e0 && n < INH + TO + 100) begin
      @(negedge master_clk);
      n++;
    end
    compared++;
    if (err_cnt == e0 || (err_cyc - acc_cyc) > INH + TO + 3 ||
        (err_cyc - acc_cyc) < INH + TO - 3) begin
      mismatched++;
      $display("FAIL timeout_latency: got %0d expected %0d (+-3)",
               (err_cnt == e0) ? -1 : err_cyc - acc_cyc, INH + TO);
    end
    @(negedge master_clk);
    check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("timeout_busy", tx_busy, 0);
`else
    d0 = done_cnt;
    e0 = err_cnt;
    i0 = inh_phases;
    start(8'hA5);
    device(20, 1'b0, -1, -1, got);
    device(20, 1'b0, -1, -1, got);
    device(20, 1'b1, -1, -1, got);
    wait_idle();
    check("retry_frame", got, model_frame(8'hA5));
    check("retry_phases", inh_phases - i0, 3);
    check("retry_done", done_cnt - d0, 1);
    check("retry_err", err_cnt - e0, 0);
`endif

    repeat (5) @(negedge master_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
